// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITER = 32;
  localparam int MD_CW   = $clog2(MD_ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: subtract the divisor when it fits and emit the quotient bit.
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   prem,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);

  logic [XLEN:0] diff;

  assign diff     = prem - {1'b0, divisor};
  assign qbit     = (prem >= {1'b0, divisor});
  // The kept remainder is always below the divisor, so XLEN bits suffice.
  assign rem_next = qbit ? diff[XLEN-1:0] : prem[XLEN-1:0];

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Optional MD_FAST_MUL_EN: single-cycle multiplier, multiplies go IDLE -> FIX.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t         state;
  logic [MD_CW-1:0]  count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              is_div;
  logic              q_neg;
  logic              r_neg;
  logic              b_zero;

  logic              signed_op;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     prem;
  logic [XLEN-1:0]   rem_next;
  logic              qbit;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   quo_fix;

  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[XLEN-1]) ? -a : a;
  assign b_mag     = (signed_op && b[XLEN-1]) ? -b : b;

  // acc holds {remainder, dividend/quotient} for divide and
  // {partial product, remaining multiplier bits} for multiply.
  assign prem    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);

  md_div_step #(.XLEN(XLEN)) u_div_step (
    .prem     (prem),
    .divisor  (opnd),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign prod_fix = q_neg ? -acc : acc;
  assign rem_fix  = r_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  // A zero divisor leaves an all-ones quotient that must not be sign-fixed.
  assign quo_fix  = (q_neg && !b_zero) ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div <= op[1];
            opnd   <= b_mag;
            acc    <= {{XLEN{1'b0}}, a_mag};
            q_neg  <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg  <= signed_op & a[XLEN-1];
            b_zero <= (b == '0);
            count  <= '0;
            busy   <= 1'b1;
`ifdef MD_FAST_MUL_EN
            if (!op[1]) begin
              acc   <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
              state <= FIX;
            end else begin
              state <= CALC;
            end
`else
            state  <= CALC;
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) acc <= {rem_next, acc[XLEN-2:0], qbit};
            else        acc <= {mul_sum, acc[XLEN-1:1]};
            count <= count + MD_CW'(1);
            if (count == MD_CW'(MD_ITER - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed, random, back-to-back, flush, reset and move cases.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  md_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model from the arithmetic definition of each instruction.
  function automatic void md_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
    longint      ps;
    logic [63:0] pu;
    int          xi, yi, qi, ri;
    xi = x;
    yi = y;
    h = '0;
    l = '0;
    case (o)
      MD_MULT: begin
        ps = longint'(xi) * longint'(yi);
        pu = ps;
        h = pu[63:32];
        l = pu[31:0];
      end
      MD_MULTU: begin
        pu = {32'h0, x} * {32'h0, y};
        h = pu[63:32];
        l = pu[31:0];
      end
      MD_DIV: begin
        if (y == 0) begin
          h = x; l = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = 32'h0; l = 32'h8000_0000;
        end else begin
          qi = xi / yi;
          ri = xi % yi;
          h = ri;
          l = qi;
        end
      end
      default: begin
        if (y == 0) begin
          h = x; l = 32'hFFFF_FFFF;
        end else begin
          h = x % y;
          l = x / y;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return o[1] ? DIV_LAT : MUL_LAT;
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t_b  [6] = '{32'h2, 32'h5, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] eh, el;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      md_model(t_op[i], t_a[i], t_b[i], eh, el);
      issue(t_op[i], t_a[i], t_b[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b exp 1", i, busy); end
      wait_done(cyc);
      checks++; if (cyc !== exp_lat(t_op[i])) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, cyc, exp_lat(t_op[i])); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, el); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_end got %b exp 0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y, eh, el;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_val();
      y = pick_val();
      md_model(o, x, y, eh, el);
      issue(o, x, y);
      wait_done(cyc);
      checks++; if (cyc !== exp_lat(o)) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, cyc, exp_lat(o)); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h got %h exp %h", i, o, x, y, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h exp %h", i, o, x, y, lo, el); end
    end
  endtask

  // Each new start is issued in the same cycle that done is high.
  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] x, y, eh, el;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = 32'($urandom_range(1, 1000));
      md_model(o, x, y, eh, el);
      issue(o, x, y);
      wait_done(cyc);
      checks++; if (cyc !== exp_lat(o)) begin errors++; $display("FAIL b2b%0d_latency got %0d exp %0d", i, cyc, exp_lat(o)); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL b2b%0d_hi got %h exp %h", i, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL b2b%0d_lo got %h exp %h", i, lo, el); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int seen_done, seen_busy;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    mtlo = 1'b0; wdata = 32'h0000_5555;
    mthi = 1'b0; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL mthi_idle got %h exp 0000aaaa", hi); end
    checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL mtlo_idle got %h exp 00005555", lo); end
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1; op = MD_MULTU; a = 32'h3; b = 32'h4;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL flush_hi got %h exp 0000aaaa", hi); end
    checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL flush_lo got %h exp 00005555", lo); end
    seen_done = 0; seen_busy = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses exp 0", seen_done); end
    checks++; if (seen_busy !== 0) begin errors++; $display("FAIL flush_start_ignored got %0d busy cycles exp 0", seen_busy); end
    checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL flush_hi_late got %h exp 0000aaaa", hi); end
  endtask

  task automatic test_moves();
    int cyc;
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mtlo = 1'b0; mthi = 1'b0;
    checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL mtlo_busy got %h exp 00005555", lo); end
    checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL mthi_busy got %h exp 0000aaaa", hi); end
    wait_done(cyc);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_after_mt_lo got %h exp 0000000e", lo); end
    checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_after_mt_hi got %h exp 00000002", hi); end
    // start with a simultaneous move: the move must be dropped
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1357_9BDF;
    issue(MD_MULTU, 32'd3, 32'd4);
    mthi = 1'b0; mtlo = 1'b0;
    wait_done(cyc);
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL start_wins_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL start_wins_lo got %h exp 0000000c", lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    issue(MD_DIV, 32'hFFFF_FF00, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo got %h exp 0", lo); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo_late got %h exp 0", lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_moves();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits in EX, in parallel with the ALU. It accepts MULT/MULTU/DIV/DIVU from the EX stage and holds HI/LO. Its `hi`/`lo` outputs feed the 32-bit 4:1 writeback-select mux that serves MFHI/MFLO. The hazard unit stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32, operand and HI/LO width.

Ports:
- `clk`, input, 1: rising-edge clock. One clock only.
- `rst`, input, 1: reset. Synchronous and active-high.
- `start`, input, 1: launch the operation in `op`. Sampled only in IDLE.
- `op`, input, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, input, XLEN: rs operand (multiplicand / dividend).
- `b`, input, XLEN: rt operand (multiplier / divisor).
- `mthi`, input, 1: write `wdata` to HI.
- `mtlo`, input, 1: write `wdata` to LO.
- `wdata`, input, XLEN: data for MTHI/MTLO.
- `flush`, input, 1: exception cancel. Aborts an in-flight operation.
- `busy`, output, 1: operation in flight.
- `done`, output, 1: one-cycle pulse. HI/LO were updated at the previous edge.
- `hi`, output, XLEN: HI register.
- `lo`, output, XLEN: LO register.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: 32 iterations, counter 0..31.
  - FIX: sign correction and HI/LO write.
- IDLE, `start`=1:
  - Latch magnitudes |a| and |b| for signed ops, raw values for unsigned.
  - Latch the quotient sign (sa^sb) and the remainder sign (sa).
  - Go to CALC.
- CALC, multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC exits to FIX after count 31.
- FIX, multiply: negate the 64-bit product if signed and the sign is negative. HI = product[63:32], LO = product[31:0].
- FIX, divide: LO = quotient, HI = remainder. Quotient negated if its sign is negative; remainder takes the dividend's sign.
- FIX then returns to IDLE.
- Divide by zero (b==0): HI = a, LO = 32'hFFFFFFFF, no sign fix. Same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural result of the magnitude arithmetic.
- `start` while not IDLE: ignored.
- `mthi`/`mtlo` in IDLE: write the register at the next edge.
- `mthi`/`mtlo` while busy: ignored. The hazard unit must stall them.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the move is dropped.
- `flush` in CALC/FIX: return to IDLE next edge, HI/LO unchanged, no `done`.
- `flush` in IDLE: blocks a same-cycle `start`.
- `rst` overrides everything, including mid-operation.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Let E0 be the edge that samples `start`:
  - `busy`=1 after E0.
  - CALC covers E1..E32 inclusive.
  - FIX writes HI/LO at E33.
  - After E33: `busy`=0 and `done`=1 for one cycle.
- Total occupancy is 33 cycles. A new `start` is accepted in the cycle where `done`=1.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.
- MTHI/MTLO latency: 1 cycle.

## Configuration
- `MD_FAST_MUL_EN` defined:
  - MULT/MULTU compute a full 64-bit product with a single-cycle multiplier.
  - The path is IDLE → FIX, so HI/LO are written at E1.
  - `busy` is high for one cycle; `done` is high after E1.
  - Division is unchanged.
- `MD_FAST_MUL_EN` undefined: all operations use the 33-cycle iterative path.
- Results are identical in both builds; only latency differs.

## Structure
- Package `md_pkg`:
  - `op` encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State enum: IDLE, CALC, FIX.
  - Constant MD_ITER = 32.
- Sub-module `md_div_step`: combinational single restoring-division step.
  - Inputs: partial remainder and divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once and reused each CALC cycle.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → after 33 cycles HI=0x00000001, LO=0xFFFFFFFE; `done` pulses once.
- MULT a=-3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - With `MD_FAST_MUL_EN`: same result at E1.
- DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → HI=0x00001234, LO=0xFFFFFFFF after 33 cycles.
- Sequence: MTHI 0xAAAA, then start DIVU 100/7; at cycle 10 pulse `flush` with `start`=1.
  - Required: IDLE next cycle, HI=0xAAAA, no `done`, the second start ignored.
- `rst` mid-CALC → next cycle `busy`=0 and HI=LO=0.
- `mtlo` while busy → LO unchanged.
